uart6551_baudgen: RTL and testbench
===================================

// Module: uart6551_baudgen
// PURPOSE
//  6551 ACIA baud-rate generator. Consumes the 3.6864 MHz clock enable XTAL_EN (2x the 1.8432 MHz crystal)
//  from the ACIA clock divider and produces the 16x and 1x bit enables used by the transmitter and receiver.
//  Programmable divisor from control register bits SBR[3:0]; receiver clock source selected by RCS.
//  Synchronises the external RxC pin.
// PARAMETERS
//  SYNC_STAGES  2   flops in the RXC_PIN synchroniser (>=2)
//  RX_MID       8   16x ticks from RX_PHASE_CLR to first RX_SAMPLE_EN (mid-bit)
// PORTS
//  CLK           in   1  system clock; all logic on this edge
//  RESET_N       in   1  asynchronous active-low reset
//  XTAL_EN       in   1  1-cycle enable at 3.6864 MHz
//  BAUD_SEL      in   4  control reg SBR; 0 = external 16x clock on RxC
//  RCS           in   1  1 = rx from baud generator, 0 = rx from RxC pin
//  RXC_PIN       in   1  external RxC level (asynchronous)
//  TX_PHASE_CLR  in   1  restart tx bit phase (tx idle->start)
//  RX_PHASE_CLR  in   1  restart rx bit phase (start-bit falling edge)
//  TX_16X_EN     out  1  1-cycle tx 16x tick
//  RX_16X_EN     out  1  1-cycle rx 16x tick
//  TX_BIT_EN     out  1  1-cycle tick every 16th TX_16X_EN
//  RX_SAMPLE_EN  out  1  1-cycle mid-bit rx sample tick
//  RXC_OUT       out  1  internal 16x clock level for the RxC pin, ~50% duty
// BEHAVIOUR
//  - Reset: all outputs 0; divisor count 0; both phase counters 0; synchroniser 0.
//  - Divisor D (XTAL_EN pulses per 16x tick) = 2*N, 13-bit. N by SBR 1..15: 2304,1536,1048,856,768,384,192,
//    96,64,48,32,24,16,12,6.
//  - Counter advances only on XTAL_EN. With XTAL_EN=1 and count==D-1, count<=0 and the internal 16x tick is
//    registered: the enable asserts for exactly one CLK on the following cycle.
//  - BAUD_SEL is registered each cycle. A change resets the count to 0 and suppresses any tick that cycle;
//    the new rate applies from there.
//  - RXC_OUT: registered; 1 while count >= D/2, else 0. Held 0 when BAUD_SEL==0.
//  - RxC path: SYNC_STAGES-flop synchroniser, then rising-edge detect -> ext tick.
//    Pin edge to tick latency is SYNC_STAGES+1 CLK.
//  - Source select: TX_16X_EN = (SBR==0) ? ext tick : gen tick.
//    RX_16X_EN = (RCS && SBR!=0) ? gen tick : ext tick.
//  - TX phase: 4-bit counter incremented on TX_16X_EN. TX_BIT_EN asserts on the cycle after the counter wraps
//    15->0. TX_PHASE_CLR forces 0 and wins over a simultaneous tick; the next TX_BIT_EN follows 16 ticks later.
//  - RX phase: RX_PHASE_CLR loads 16-RX_MID and wins over a simultaneous tick. RX_SAMPLE_EN asserts on the
//    cycle after the wrap 15->0: first after RX_MID ticks, then every 16.
//  - Tick paths and phase counters are independent; simultaneous tx/rx ticks are allowed.
//  - Reset mid-count: everything returns to reset values immediately; no partial pulses.
// STRUCTURE
//  - uart6551_pkg holds the 16-entry N table (function baud_div(sel)->13 bit), BAUD_EXT=4'd0, and DIV_W=13.
//  - Sub-module uart6551_phase16: 4-bit phase counter with tick, clear, load value and wrap pulse out.
//    Instantiated twice (tx, rx).
// TESTING
//  Bench drives XTAL_EN 1-of-17 cycles.
//  1 Reset held, RXC_PIN toggling -> all outputs 0; release -> first TX_16X_EN (SBR=15) after exactly
//    12 XTAL_EN pulses, then every 12.
//  2 SBR=8 -> TX_16X_EN every 192 XTAL_EN. RXC_OUT high for 96 of the 192 pulses.
//    TX_BIT_EN every 16 ticks = 3072 pulses.
//  3 SBR 15->14 at count 5 -> no tick that cycle; next tick 24 XTAL_EN pulses after the change.
//  4 SBR=0, RCS=1, RXC_PIN rising edges -> TX_16X_EN and RX_16X_EN each 3 CLK after each edge; RXC_OUT stays 0.
//  5 SBR=14, RCS=0 -> TX ticks from generator and RX ticks only from RxC edges.
//  6 RX_PHASE_CLR coincident with RX_16X_EN -> RX_SAMPLE_EN after 8 further ticks, then every 16;
//    assert reset mid-sequence -> no pulse.

Source files
------------

// File: rtl/uart6551_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart6551_pkg
// Description : Shared constants and the SBR divisor table for the 6551 ACIA
//               baud-rate generator.
//               DIV_W    - width of the divisor and of the generator count
//               PHASE_W  - width of the 16x bit-phase counters
//               BAUD_EXT - SBR code that selects the external 16x RxC clock
//               baud_div - SBR code -> XTAL_EN pulses per 16x tick
// Revision    : 1.0 - initial release
// ============================================================================
package uart6551_pkg;

    localparam int DIV_W   = 13;
    localparam int PHASE_W = 4;

    localparam logic [3:0] BAUD_EXT = 4'd0;

    // The ACIA clock divider delivers XTAL_EN at twice the crystal rate, so
    // every entry of the classic crystal divisor table (N) is doubled here.
    // The result is the number of XTAL_EN pulses per 16x tick. Code 0 has no
    // internal rate and returns 0.
    function automatic logic [DIV_W-1:0] baud_div(input logic [3:0] sel);
        logic [DIV_W-1:0] n;
        case (sel)
            4'd1:    n = 13'd2304;
            4'd2:    n = 13'd1536;
            4'd3:    n = 13'd1048;
            4'd4:    n = 13'd856;
            4'd5:    n = 13'd768;
            4'd6:    n = 13'd384;
            4'd7:    n = 13'd192;
            4'd8:    n = 13'd96;
            4'd9:    n = 13'd64;
            4'd10:   n = 13'd48;
            4'd11:   n = 13'd32;
            4'd12:   n = 13'd24;
            4'd13:   n = 13'd16;
            4'd14:   n = 13'd12;
            4'd15:   n = 13'd6;
            default: n = 13'd0;
        endcase
        // Largest N is 2304, so doubling never overflows 13 bits.
        return {n[DIV_W-2:0], 1'b0};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart6551_phase16.sv
`default_nettype none
// ============================================================================
// Module      : uart6551_phase16
// Description : 4-bit bit-phase counter. Advances on each 16x tick and emits
//               a one-cycle pulse on the cycle after it wraps 15 -> 0.
//               A clear loads load_val and takes priority over a tick.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               tick     - 16x tick (advance by one)
//               clr      - restart phase: load load_val, suppress wrap
//               load_val - phase value loaded by clr
//               wrap     - one-cycle pulse following a 15 -> 0 wrap
// Revision    : 1.0 - initial release
// ============================================================================
module uart6551_phase16
    import uart6551_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               tick,
    input  logic               clr,
    input  logic [PHASE_W-1:0] load_val,
    output logic               wrap
);

    localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);
    localparam logic [PHASE_W-1:0] PHASE_MAX = '1;

    logic [PHASE_W-1:0] phase;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase <= '0;
            wrap  <= 1'b0;
        end else if (clr) begin
            // A restart discards a coincident tick, including one that would
            // otherwise have produced a wrap pulse.
            phase <= load_val;
            wrap  <= 1'b0;
        end else begin
            wrap <= tick && (phase == PHASE_MAX);
            if (tick) begin
                phase <= phase + PHASE_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart6551_baudgen.sv
`default_nettype none
// ============================================================================
// Module      : uart6551_baudgen
// Description : 6551 ACIA baud-rate generator. Divides the 3.6864 MHz
//               xtal_en stream by the SBR-selected divisor to form the
//               internal 16x tick, synchronises the external RxC pin into an
//               alternative 16x tick, selects tx/rx tick sources and derives
//               the tx bit tick and the mid-bit rx sample tick.
// Parameters  : SYNC_STAGES - flops in the rxc_pin synchroniser (>= 2)
//               RX_MID      - 16x ticks from rx_phase_clr to first sample
// Ports       : clk          - system clock
//               reset_n      - asynchronous active-low reset
//               xtal_en      - one-cycle enable at 3.6864 MHz
//               baud_sel     - SBR[3:0]; 0 selects the external RxC clock
//               rcs          - 1: rx from generator, 0: rx from RxC pin
//               rxc_pin      - external RxC level (asynchronous)
//               tx_phase_clr - restart tx bit phase
//               rx_phase_clr - restart rx bit phase (start-bit edge)
//               tx_16x_en    - one-cycle tx 16x tick
//               rx_16x_en    - one-cycle rx 16x tick
//               tx_bit_en    - one-cycle tick every 16th tx_16x_en
//               rx_sample_en - one-cycle mid-bit rx sample tick
//               rxc_out      - internal 16x clock level, ~50% duty
// Revision    : 1.0 - initial release
// ============================================================================
module uart6551_baudgen
    import uart6551_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int RX_MID      = 8
)
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       xtal_en,
    input  logic [3:0] baud_sel,
    input  logic       rcs,
    input  logic       rxc_pin,
    input  logic       tx_phase_clr,
    input  logic       rx_phase_clr,
    output logic       tx_16x_en,
    output logic       rx_16x_en,
    output logic       tx_bit_en,
    output logic       rx_sample_en,
    output logic       rxc_out
);

    localparam logic [DIV_W-1:0]   DIV_ONE = DIV_W'(1);
    // Starting the rx phase this far from the wrap puts the first sample
    // RX_MID ticks after the start-bit edge, i.e. mid-bit.
    localparam logic [PHASE_W-1:0] RX_LOAD = PHASE_W'(16 - RX_MID);

    // ------------------------------------------------------------------
    // Internal divisor
    // ------------------------------------------------------------------
    logic [3:0]       sel_q;
    logic             sel_change;
    logic             gen_on;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] last_cnt;
    logic [DIV_W-1:0] half_div;
    logic [DIV_W-1:0] count;
    logic             gen_tick;
    logic             rxc_q;

    assign div        = baud_div(sel_q);
    assign last_cnt   = div - DIV_ONE;
    assign half_div   = div >> 1;
    assign gen_on     = (sel_q != BAUD_EXT);
    // The divisor in use always follows the registered selection, so any
    // difference from the live input marks a rate change this cycle.
    assign sel_change = (baud_sel != sel_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_q    <= BAUD_EXT;
            count    <= '0;
            gen_tick <= 1'b0;
            rxc_q    <= 1'b0;
        end else begin
            sel_q    <= baud_sel;
            gen_tick <= 1'b0;
            rxc_q    <= gen_on && (count >= half_div);
            if (sel_change || !gen_on) begin
                // A rate change restarts the divisor and drops any tick that
                // would have fallen on this cycle.
                count <= '0;
            end else if (xtal_en) begin
                if (count == last_cnt) begin
                    count    <= '0;
                    gen_tick <= 1'b1;
                end else begin
                    count <= count + DIV_ONE;
                end
            end
        end
    end

    assign rxc_out = rxc_q;

    // ------------------------------------------------------------------
    // External RxC path: synchronise, then register the rising edge.
    // Pin edge to ext_tick is SYNC_STAGES + 1 clocks.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_prev;
    logic                   ext_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync      <= '0;
            sync_prev <= 1'b0;
            ext_tick  <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], rxc_pin};
            sync_prev <= sync[SYNC_STAGES-1];
            ext_tick  <= sync[SYNC_STAGES-1] && !sync_prev;
        end
    end

    // ------------------------------------------------------------------
    // Source selection. The transmitter always uses the external clock
    // when SBR is 0; the receiver additionally needs rcs to pick the
    // generator.
    // ------------------------------------------------------------------
    assign tx_16x_en = gen_on ? gen_tick : ext_tick;
    assign rx_16x_en = (rcs && gen_on) ? gen_tick : ext_tick;

    // ------------------------------------------------------------------
    // Bit-phase counters
    // ------------------------------------------------------------------
    uart6551_phase16 u_tx_phase (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (tx_16x_en),
        .clr      (tx_phase_clr),
        .load_val ('0),
        .wrap     (tx_bit_en)
    );

    uart6551_phase16 u_rx_phase (
        .clk      (clk),
        .reset_n  (reset_n),
        .tick     (rx_16x_en),
        .clr      (rx_phase_clr),
        .load_val (RX_LOAD),
        .wrap     (rx_sample_en)
    );

endmodule
`default_nettype wire

// File: tb/tb_uart6551_baudgen.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart6551_baudgen
// Description : Self-checking bench for uart6551_baudgen. xtal_en is driven
//               one cycle in seventeen; a table of SBR codes with their
//               hand-computed tick periods is applied in a loop, followed by
//               directed sequences for rate change, external RxC, source
//               selection and the rx sample phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart6551_baudgen;

    logic       clk          = 1'b0;
    logic       reset_n      = 1'b1;
    logic       xtal_en      = 1'b0;
    logic [3:0] baud_sel     = 4'd15;
    logic       rcs          = 1'b1;
    logic       rxc_pin      = 1'b0;
    logic       tx_phase_clr = 1'b0;
    logic       rx_phase_clr = 1'b0;
    logic       tx_16x_en;
    logic       rx_16x_en;
    logic       tx_bit_en;
    logic       rx_sample_en;
    logic       rxc_out;

    int n_tests = 0;
    int n_fail  = 0;
    int xph     = 0;

    typedef struct {
        logic [3:0] sel;
        logic       rcs;
        int         pulses;
        logic       exp_rx;
    } vec_t;

    vec_t tbl [7];

    uart6551_baudgen #(
        .SYNC_STAGES (2),
        .RX_MID      (8)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .xtal_en      (xtal_en),
        .baud_sel     (baud_sel),
        .rcs          (rcs),
        .rxc_pin      (rxc_pin),
        .tx_phase_clr (tx_phase_clr),
        .rx_phase_clr (rx_phase_clr),
        .tx_16x_en    (tx_16x_en),
        .rx_16x_en    (rx_16x_en),
        .tx_bit_en    (tx_bit_en),
        .rx_sample_en (rx_sample_en),
        .rxc_out      (rxc_out)
    );

    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; outputs are read 1 time unit after the edge and xtal_en is
    // set up for the following edge.
    task automatic step();
        @(posedge clk);
        #1;
        xph     = (xph == 16) ? 0 : xph + 1;
        xtal_en = (xph == 16);
    endtask

    // Make sure the next edge carries no xtal_en pulse.
    task automatic align();
        while (xtal_en) step();
    endtask

    function automatic logic sig(input int which);
        case (which)
            0:       return tx_16x_en;
            1:       return rx_16x_en;
            2:       return tx_bit_en;
            default: return rx_sample_en;
        endcase
    endfunction

    function automatic logic all_zero();
        return !(tx_16x_en | rx_16x_en | tx_bit_en | rx_sample_en | rxc_out);
    endfunction

    // Step until the selected output pulses; counts xtal_en pulses consumed,
    // tx/rx ticks seen and pulses at which rxc_out was high.
    task automatic wait_sig(input int which, input int max_cycles,
                            output int pulses, output int txt, output int rxt,
                            output int hi, output bit ok);
        pulses = 0; txt = 0; rxt = 0; hi = 0; ok = 1'b0;
        for (int c = 0; c < max_cycles && !ok; c++) begin
            if (xtal_en) begin
                pulses++;
                if (rxc_out) hi++;
            end
            step();
            if (tx_16x_en) txt++;
            if (rx_16x_en) rxt++;
            if (sig(which)) ok = 1'b1;
        end
    endtask

    // One RxC period of 8 clocks, pin high for the first 4.
    task automatic ext_period(output bit st, output bit ss);
        st = 1'b0; ss = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rxc_pin = (i < 4);
            step();
            if (rx_16x_en)    st = 1'b1;
            if (rx_sample_en) ss = 1'b1;
        end
    endtask

    initial begin
        int p, t, r, h, bad, cnt, first;
        bit ok, st, ss;

        tbl[0] = '{4'd15, 1'b1, 12,  1'b1};
        tbl[1] = '{4'd14, 1'b0, 24,  1'b0};
        tbl[2] = '{4'd13, 1'b1, 32,  1'b1};
        tbl[3] = '{4'd12, 1'b1, 48,  1'b1};
        tbl[4] = '{4'd11, 1'b0, 64,  1'b0};
        tbl[5] = '{4'd10, 1'b1, 96,  1'b1};
        tbl[6] = '{4'd9,  1'b1, 128, 1'b1};

        // ---------------- 1: reset, then SBR=15 ----------------
        #2 reset_n = 1'b0;
        #1;
        check("t1_async_reset", all_zero(), 1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            rxc_pin = i[1];
            step();
            if (!all_zero()) bad++;
        end
        check("t1_reset_outputs", bad, 0);
        rxc_pin = 1'b0;
        repeat (4) step();
        align();
        reset_n = 1'b1;
        wait_sig(0, 12 * 17 + 40, p, t, r, h, ok);
        check("t1_first_tick_pulses", p, 12);
        check("t1_first_tick_rx", rx_16x_en, 1);
        wait_sig(0, 12 * 17 + 40, p, t, r, h, ok);
        check("t1_period_pulses", p, 12);

        // ---------------- table of rates ----------------
        foreach (tbl[k]) begin
            align();
            baud_sel = tbl[k].sel;
            rcs      = tbl[k].rcs;
            wait_sig(0, tbl[k].pulses * 17 + 40, p, t, r, h, ok);
            check($sformatf("tbl%0d_first_pulses", k), p, tbl[k].pulses);
            check($sformatf("tbl%0d_rx_tick", k), rx_16x_en, tbl[k].exp_rx);
            wait_sig(0, tbl[k].pulses * 17 + 40, p, t, r, h, ok);
            check($sformatf("tbl%0d_period_pulses", k), p, tbl[k].pulses);
        end

        // ---------------- 2: SBR=8, rxc_out duty, bit tick ----------------
        align();
        baud_sel = 4'd8;
        rcs      = 1'b1;
        wait_sig(0, 192 * 17 + 40, p, t, r, h, ok);
        check("t2_first_pulses", p, 192);
        wait_sig(0, 192 * 17 + 40, p, t, r, h, ok);
        check("t2_period_pulses", p, 192);
        check("t2_rxc_high_pulses", h, 96);
        tx_phase_clr = 1'b1;
        step();
        tx_phase_clr = 1'b0;
        wait_sig(2, 3072 * 17 + 200, p, t, r, h, ok);
        check("t2_bit_seen", ok, 1);
        check("t2_bit_pulses", p, 3072);
        check("t2_bit_ticks", t, 16);

        // ---------------- 3: rate change ----------------
        align();
        baud_sel = 4'd15;
        wait_sig(0, 12 * 17 + 40, p, t, r, h, ok);
        cnt = 0;
        while (cnt < 5) begin
            if (xtal_en) cnt++;
            step();
        end
        align();
        baud_sel = 4'd14;
        step();
        check("t3_change_no_tick", tx_16x_en, 0);
        wait_sig(0, 24 * 17 + 40, p, t, r, h, ok);
        check("t3_after_change_pulses", p, 24);
        // Change on the very pulse that would have produced a tick.
        cnt = 0;
        while (cnt < 23) begin
            if (xtal_en) cnt++;
            step();
        end
        while (!xtal_en) step();
        baud_sel = 4'd15;
        step();
        check("t3_suppress_tick", tx_16x_en, 0);
        wait_sig(0, 12 * 17 + 40, p, t, r, h, ok);
        check("t3_suppress_next_pulses", p, 12);

        // ---------------- 4: external 16x clock ----------------
        align();
        baud_sel = 4'd0;
        rcs      = 1'b1;
        repeat (4) step();
        bad = 0;
        for (int e = 0; e < 3; e++) begin
            rxc_pin = 1'b1;
            step(); step();
            if (tx_16x_en || rx_16x_en) bad++;
            step();
            check($sformatf("t4_tx_lat%0d", e), tx_16x_en, 1);
            check($sformatf("t4_rx_lat%0d", e), rx_16x_en, 1);
            step();
            if (tx_16x_en || rx_16x_en) bad++;
            rxc_pin = 1'b0;
            repeat (4) step();
            if (rxc_out) bad++;
        end
        check("t4_no_stray_ticks", bad, 0);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (tx_16x_en || rx_16x_en || rxc_out) bad++;
        end
        check("t4_idle_no_gen", bad, 0);

        // ---------------- 5: SBR=14, rx from RxC ----------------
        align();
        baud_sel = 4'd14;
        rcs      = 1'b0;
        wait_sig(0, 24 * 17 + 40, p, t, r, h, ok);
        check("t5_tx_pulses", p, 24);
        check("t5_rx_none", r, 0);
        wait_sig(0, 24 * 17 + 40, p, t, r, h, ok);
        check("t5_tx_period", p, 24);
        check("t5_rx_none2", r, 0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            ext_period(st, ss);
            if (st) cnt++;
        end
        check("t5_rx_ext_ticks", cnt, 3);

        // ---------------- 6: rx sample phase ----------------
        baud_sel = 4'd15;
        rcs      = 1'b0;
        repeat (4) step();
        rxc_pin = 1'b1;
        step(); step(); step();
        check("t6_tick_seen", rx_16x_en, 1);
        rx_phase_clr = 1'b1;
        step();
        rx_phase_clr = 1'b0;
        rxc_pin = 1'b0;
        repeat (4) step();
        first = 0;
        for (int k = 1; k <= 20 && first == 0; k++) begin
            ext_period(st, ss);
            if (ss) first = k;
        end
        check("t6_first_sample", first, 8);
        first = 0;
        for (int k = 1; k <= 30 && first == 0; k++) begin
            ext_period(st, ss);
            if (ss) first = k;
        end
        check("t6_next_sample", first, 16);
        repeat (5) ext_period(st, ss);
        rxc_pin = 1'b1;
        step(); step();
        reset_n = 1'b0;
        #1;
        check("t6_reset_async", all_zero(), 1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            rxc_pin = (i < 2);
            step();
            if (!all_zero()) bad++;
        end
        check("t6_reset_no_pulse", bad, 0);
        align();
        reset_n = 1'b1;
        cnt = 0; bad = 0;
        for (int k = 0; k < 12; k++) begin
            ext_period(st, ss);
            if (st) cnt++;
            if (ss) bad++;
        end
        check("t6_post_reset_ticks", cnt, 12);
        check("t6_post_reset_no_sample", bad, 0);
        first = 0;
        for (int k = 1; k <= 10 && first == 0; k++) begin
            ext_period(st, ss);
            if (ss) first = k;
        end
        check("t6_post_reset_sample", first, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
